// File: rtl/mvu_weight_replay.sv
// Weight sequencer: captures one NF*SF weight set, then replays it cfg_reps times to the compute core.
// Optional build macro MVU_WGT_REPLAY_STALL_CNT_EN adds the stall_cnt output.
module mvu_weight_replay #(
  parameter int MW           = 9,
  parameter int MH           = 512,
  parameter int PE           = 4,
  parameter int SIMD         = 9,
  parameter int WEIGHT_WIDTH = 8,
  localparam int DEPTH = (MH/PE)*(MW/SIMD),
  localparam int WBITS = (PE*SIMD*WEIGHT_WIDTH+7)/8*8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WBITS-1:0] s_axis_wload_tdata,
  input  logic             s_axis_wload_tvalid,
  output logic             s_axis_wload_tready,
  output logic [WBITS-1:0] m_axis_weights_tdata,
  output logic             m_axis_weights_tvalid,
  input  logic             m_axis_weights_tready,
  input  logic [15:0]      cfg_reps,
  input  logic             start,
  input  logic             reload,
`ifdef MVU_WGT_REPLAY_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
`endif
  output logic             loaded,
  output logic             busy
);

  typedef enum logic [1:0] {LOAD, IDLE, REPLAY, DRAIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  state_t            state;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [15:0]       rep_cnt, reps_q;
  logic              reload_pend;
  logic              rd_inflight;
  logic [WBITS-1:0]  mem [DEPTH];
  logic [WBITS-1:0]  mem_q;
  logic [WBITS-1:0]  buf0, buf1;
  logic [1:0]        cnt;

  logic       s_hs, pop, push, rd_en, pass_end, last_pass, start_ok;
  logic [1:0] occ;

  assign s_hs      = s_axis_wload_tvalid && (state == LOAD);
  assign pop       = (cnt != 2'd0) && m_axis_weights_tready;
  assign push      = rd_inflight;
  // occupancy counts the read still in the memory pipe so the skid buffer never overflows
  assign occ       = cnt + {1'b0, rd_inflight};
  assign rd_en     = (state == REPLAY) && ((occ < 2'd2) || pop);
  assign pass_end  = rd_en && (rd_addr == LAST);
  assign last_pass = (reps_q != 16'd0) && (rep_cnt + 16'd1 == reps_q);
  assign start_ok  = (state == IDLE) && start && loaded && !reload;

  assign s_axis_wload_tready   = (state == LOAD);
  assign m_axis_weights_tvalid = (cnt != 2'd0);
  assign m_axis_weights_tdata  = buf0;
  assign busy                  = (state != IDLE);

  // weight storage is never reset
  always_ff @(posedge ap_clk) begin
    if (s_hs) mem[wr_addr] <= s_axis_wload_tdata;
    if (rd_en) mem_q <= mem[rd_addr];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= LOAD;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rep_cnt     <= '0;
      reps_q      <= '0;
      reload_pend <= 1'b0;
      loaded      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (s_hs) begin
            if (wr_addr == LAST) begin
              wr_addr <= '0;
              loaded  <= 1'b1;
              state   <= IDLE;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        IDLE: begin
          if (reload) begin
            state  <= LOAD;
            loaded <= 1'b0;
          end else if (start_ok) begin
            state       <= REPLAY;
            reps_q      <= cfg_reps;
            rep_cnt     <= '0;
            rd_addr     <= '0;
            reload_pend <= 1'b0;
          end
        end
        REPLAY: begin
          if (reload) reload_pend <= 1'b1;
          if (rd_en) begin
            if (pass_end) begin
              rd_addr <= '0;
              rep_cnt <= rep_cnt + 16'd1;
              if (last_pass || reload_pend || reload) state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (reload) reload_pend <= 1'b1;
          if ((cnt == 2'd0) && !rd_inflight) begin
            if (reload_pend || reload) begin
              state       <= LOAD;
              loaded      <= 1'b0;
              reload_pend <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // two-entry skid buffer; buf0 is always the head presented on the output
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rd_inflight <= 1'b0;
      cnt         <= '0;
      buf0        <= '0;
      buf1        <= '0;
    end else begin
      rd_inflight <= rd_en;
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= mem_q;
          else             buf1 <= mem_q;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) buf0 <= mem_q;
          else begin
            buf0 <= buf1;
            buf1 <= mem_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MVU_WGT_REPLAY_STALL_CNT_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if (((state == REPLAY) || (state == DRAIN)) && m_axis_weights_tvalid &&
             !m_axis_weights_tready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mvu_weight_replay.sv
// Bench for mvu_weight_replay: table-driven replay runs against a reference model of the weight set.
module tb_mvu_weight_replay;
  localparam int MW = 9, MH = 512, PE = 4, SIMD = 9, WW = 8;
  localparam int DEPTH = (MH/PE)*(MW/SIMD);
  localparam int WBITS = (PE*SIMD*WW+7)/8*8;

  logic             ap_clk, ap_rst;
  logic [WBITS-1:0] s_tdata;
  logic             s_tvalid, s_tready;
  logic [WBITS-1:0] m_tdata;
  logic             m_tvalid, m_tready;
  logic [15:0]      cfg_reps;
  logic             start, reload, loaded, busy;
`ifdef MVU_WGT_REPLAY_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  mvu_weight_replay #(.MW(MW), .MH(MH), .PE(PE), .SIMD(SIMD), .WEIGHT_WIDTH(WW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axis_wload_tdata(s_tdata), .s_axis_wload_tvalid(s_tvalid), .s_axis_wload_tready(s_tready),
    .m_axis_weights_tdata(m_tdata), .m_axis_weights_tvalid(m_tvalid),
    .m_axis_weights_tready(m_tready),
    .cfg_reps(cfg_reps), .start(start), .reload(reload),
`ifdef MVU_WGT_REPLAY_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .loaded(loaded), .busy(busy));

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int checks = 0, failures = 0;
  logic [WBITS-1:0] wset [DEPTH];

  typedef struct {
    int reps;
    int rdy_mode;
    int exp_beats;
    bit timing;
  } vec_t;

  task automatic chk(input string name, input logic [WBITS-1:0] act, input logic [WBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic new_set();
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < WBITS/32; j++) wset[i][j*32 +: 32] = $urandom();
  endtask

  // present beats wset[first..first+n-1] with random gaps in tvalid
  task automatic load_beats(input int first, input int n);
    int idx, cyc;
    bit hs;
    idx = first;
    cyc = 0;
    while (idx < first + n && cyc < 4*n + 50) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = wset[idx];
      @(negedge ap_clk);
      hs = s_tvalid && s_tready;
      step();
      if (hs) idx++;
      cyc++;
    end
    s_tvalid = 1'b0;
    if (idx != first + n) chk("load_timeout", idx, first + n);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    m_tready = 1'b1;
    while (busy && k < bound) begin
      step();
      k++;
    end
    @(negedge ap_clk);
    chk("idle_busy", busy, 0);
    chk("idle_loaded", loaded, 1);
    chk("idle_s_tready", s_tready, 0);
    step();
  endtask

  // expected output: beat k of a replay is wset[k mod DEPTH]
  task automatic run_replay(input int reps, input int rdy_mode, input int reload_at,
                            input int rst_at, input int exp_beats, input bit timing);
    int beats, idle, first_k, last_k;
    bit prev_stall, pulsed, rst_hit;
    logic [WBITS-1:0] prev_data;
    cfg_reps = 16'(reps);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_reps = 16'($urandom_range(1, 9));
    beats = 0; idle = 0; first_k = -1; last_k = -1;
    prev_stall = 1'b0; pulsed = 1'b0; rst_hit = 1'b0; prev_data = '0;
    for (int k = 0; k < 8000 && idle < 12; k++) begin
      m_tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, rdy_mode-1) == 0);
      reload = (reload_at > 0 && beats == reload_at && !pulsed);
      if (reload) pulsed = 1'b1;
      @(negedge ap_clk);
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, prev_data);
      end
      if (m_tvalid && first_k < 0) first_k = k;
      if (m_tvalid && m_tready) begin
        chk("beat_data", m_tdata, wset[beats % DEPTH]);
        beats++;
        last_k = k;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      idle = (m_tvalid || beats == 0) ? 0 : idle + 1;
      if (rst_at > 0 && beats == rst_at) begin
        ap_rst = 1'b1;
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_loaded", loaded, 0);
        step();
        ap_rst = 1'b0;
        rst_hit = 1'b1;
        break;
      end
      step();
    end
    reload = 1'b0;
    if (!rst_hit) chk("beat_count", beats, exp_beats);
    if (timing) begin
      chk("first_valid_lat", first_k, 2);
      chk("last_beat_cycle", last_k, 2 + exp_beats - 1);
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{reps: 3, rdy_mode: 0, exp_beats: 3*DEPTH, timing: 1'b1};
    vecs[1] = '{reps: 3, rdy_mode: 7, exp_beats: 3*DEPTH, timing: 1'b0};
    vecs[2] = '{reps: 1, rdy_mode: 2, exp_beats: DEPTH,   timing: 1'b0};
    vecs[3] = '{reps: 2, rdy_mode: 3, exp_beats: 2*DEPTH, timing: 1'b0};

    ap_rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    cfg_reps = '0; start = 1'b0; reload = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_busy", busy, 1);
    ap_rst = 1'b0;
    step();
    @(negedge ap_clk);
    chk("rst_s_tready", s_tready, 1);
    step();

    // reset in the middle of a load, then start before the load completes
    new_set();
    load_beats(0, 60);
    ap_rst = 1'b1;
    #1;
    chk("load_rst_loaded", loaded, 0);
    chk("load_rst_tvalid", m_tvalid, 0);
    step();
    ap_rst = 1'b0;
    step();
    new_set();
    load_beats(0, 50);
    start = 1'b1; cfg_reps = 16'd1;
    step();
    start = 1'b0;
    repeat (4) step();
    @(negedge ap_clk);
    chk("early_start_busy", busy, 1);
    chk("early_start_tvalid", m_tvalid, 0);
    chk("early_start_s_tready", s_tready, 1);
    step();
    load_beats(50, DEPTH - 50);
    @(negedge ap_clk);
    chk("load_done_loaded", loaded, 1);
    chk("load_done_busy", busy, 0);
    step();

    foreach (vecs[i]) begin
      run_replay(vecs[i].reps, vecs[i].rdy_mode, 0, 0, vecs[i].exp_beats, vecs[i].timing);
      wait_idle(50);
    end

    // endless replay stopped by a reload part-way through the second pass
    run_replay(0, 0, 200, 0, 2*DEPTH, 1'b0);
    @(negedge ap_clk);
    chk("reload_loaded", loaded, 0);
    chk("reload_s_tready", s_tready, 1);
    chk("reload_busy", busy, 1);
    step();
    new_set();
    load_beats(0, DEPTH);
    run_replay(1, 3, 0, 0, DEPTH, 1'b0);
    wait_idle(50);

    // reset during replay drops everything and requires a fresh load
    run_replay(2, 0, 0, 70, 0, 1'b0);
    @(negedge ap_clk);
    chk("replay_rst_s_tready", s_tready, 1);
    step();
    new_set();
    load_beats(0, DEPTH);
    run_replay(2, 4, 0, 0, 2*DEPTH, 1'b0);
    wait_idle(50);

    // start and reload together in IDLE: reload wins
    start = 1'b1; reload = 1'b1; cfg_reps = 16'd1;
    step();
    start = 1'b0; reload = 1'b0;
    @(negedge ap_clk);
    chk("sr_loaded", loaded, 0);
    chk("sr_s_tready", s_tready, 1);
    chk("sr_tvalid", m_tvalid, 0);
    step();
    new_set();
    load_beats(0, DEPTH);
    run_replay(2, 0, 0, 0, 2*DEPTH, 1'b1);
    wait_idle(50);

`ifdef MVU_WGT_REPLAY_STALL_CNT_EN
    begin
      int k;
      m_tready = 1'b0;
      cfg_reps = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      @(negedge ap_clk);
      while (!m_tvalid && k < 10) begin
        step();
        @(negedge ap_clk);
        k++;
      end
      chk("stall_first_valid", m_tvalid, 1);
      repeat (10) @(posedge ap_clk);
      #1;
      chk("stall_cnt_10", stall_cnt, 10);
      wait_idle(300);
      m_tready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge ap_clk);
      chk("stall_cnt_clr", stall_cnt, 0);
      step();
      wait_idle(300);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
